duck_rom_arbiter: RTL

Round-robin arbiter that shares one duck sprite ROM (synchronous read, clocked on the inverted `vga_clk`, 4-bit palette index output) among several sprite requesters. Typical requesters are per-duck draw engines and the HUD icon renderer. It accepts one address per cycle through a valid/ready handshake and returns each ROM word to the requester that issued it, tagged one-hot, with a fixed two-cycle latency. It sits between the sprite engines and the `*_rom` instance; the palette lookup stays downstream with each requester.

---
 rtl/duck_rom_if.sv | 27 ++
 rtl/duck_rom_arbiter.sv | 98 +++++++++
 2 files changed

// File: rtl/duck_rom_if.sv
// Requester/ROM bus for the shared duck sprite ROM arbiter.
// The master side is the requester cluster plus the ROM; the slave side is the arbiter.
interface duck_rom_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 4
) ();
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        req_lock;
   logic [NUM_REQ-1:0]        req_ready;
   logic [ADDR_W-1:0]         rom_address;
   logic [DATA_W-1:0]         rom_q;
   logic [NUM_REQ-1:0]        resp_valid;
   logic [DATA_W-1:0]         resp_data;
   logic                      busy;

   modport master (
      output req_valid, req_addr, req_lock, rom_q,
      input  req_ready, rom_address, resp_valid, resp_data, busy
   );

   modport slave (
      input  req_valid, req_addr, req_lock, rom_q,
      output req_ready, rom_address, resp_valid, resp_data, busy
   );
endinterface

// File: rtl/duck_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous duck sprite ROM among NUM_REQ requesters,
// with burst locking and a fixed two-cycle, one-hot-tagged response path.
//
// state    | meaning
// ST_ARB   | round-robin search from last+1
// ST_LOCK  | only lock_owner may be granted while it keeps req_valid high
module duck_rom_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 4
) (
   input logic       vga_clk,
   input logic       reset,
   duck_rom_if.slave bus
);
   localparam int PTR_W = $clog2(NUM_REQ);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

   localparam logic [0:0] ST_ARB  = 1'b0;
   localparam logic [0:0] ST_LOCK = 1'b1;

   logic [0:0]         lock_state;
   logic [PTR_W-1:0]   last;
   logic [PTR_W-1:0]   lock_owner;
   logic [PTR_W-1:0]   win_idx;
   logic [PTR_W-1:0]   scan_idx;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] s1_owner;
   logic [ADDR_W-1:0]  win_addr;
   logic               found;
   logic               lock_active;
   logic               xfer;

   assign lock_active = (lock_state == ST_LOCK);

   // Grant depends only on registered state and the current valid/lock inputs, never on rom_q.
   always_comb begin
      grant    = '0;
      win_idx  = last;
      scan_idx = last;
      found    = 1'b0;
      if (!reset) begin
         if (lock_active && bus.req_valid[lock_owner]) begin
            grant[lock_owner] = 1'b1;
            win_idx           = lock_owner;
         end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
               scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
               if (!found && bus.req_valid[scan_idx]) begin
                  grant[scan_idx] = 1'b1;
                  win_idx         = scan_idx;
                  found           = 1'b1;
               end
            end
         end
      end
   end

   assign xfer          = |grant;
   assign win_addr      = bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
   assign bus.req_ready = grant;

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         lock_state      <= ST_ARB;
         lock_owner      <= '0;
         last            <= LAST_IDX;
         s1_owner        <= '0;
         bus.rom_address <= '0;
         bus.resp_valid  <= '0;
         bus.resp_data   <= '0;
         bus.busy        <= 1'b0;
      end else begin
         if (xfer) begin
            last            <= win_idx;
            bus.rom_address <= win_addr;
            s1_owner        <= grant;
            if (bus.req_lock[win_idx]) begin
               lock_state <= ST_LOCK;
               lock_owner <= win_idx;
            end else begin
               lock_state <= ST_ARB;
            end
         end else begin
            s1_owner <= '0;
            // An idle cycle under lock means the owner dropped valid: the burst is abandoned.
            if (lock_active && !bus.req_valid[lock_owner]) begin
               lock_state <= ST_ARB;
            end
         end
         bus.resp_valid <= s1_owner;
         if (|s1_owner) begin
            bus.resp_data <= bus.rom_q;
         end
         bus.busy <= xfer | (|s1_owner);
      end
   end
endmodule
